elapsed_timer: RTL
==================

Name: elapsed_timer

Overview:
- Saturating up-counting interval timer; the measuring complement of the existing delay down-counter.
- Measures the number of enabled clock ticks between a start event and a stop event. Used for 1553 RT response-gap measurement and the no-response timeout.
- Captures the result with a one-cycle valid strobe.
- Raises a sticky timeout flag when the running count reaches a threshold.

Parameters:
- MAX_COUNT, default 1000: saturation ceiling in ticks; must be >0.
- TIMEOUT_COUNT, default 700: timeout threshold; 1 <= TIMEOUT_COUNT <= MAX_COUNT.
- COUNTER_WIDTH, default $clog2(MAX_COUNT+1): width of the count and capture values.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_clear  in  1  synchronous abort to idle; does not touch o_capture.
- i_en  in  1  tick enable (prescaler strobe); count advances only when high.
- i_start  in  1  single-cycle pulse; begins or restarts a measurement.
- i_stop  in  1  single-cycle pulse; ends the measurement and captures.
- o_count  out  COUNTER_WIDTH  live count.
- o_running  out  1  high in S_RUN.
- o_capture  out  COUNTER_WIDTH  last captured interval; held until the next capture.
- o_valid  out  1  one-cycle strobe; o_capture updated this cycle.
- o_timeout  out  1  sticky; count reached TIMEOUT_COUNT in the current or last measurement.
- o_saturated  out  1  sticky; count reached MAX_COUNT in the current or last measurement.

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Priority: i_rst > i_clear > stop/start logic.
- Reset values: state S_IDLE, count 0, o_capture 0, o_valid 0, o_timeout 0, o_saturated 0, o_running 0.
- States:
  - S_IDLE: count holds. i_stop is ignored.
  - S_RUN: count advances by 1 on each cycle with i_en=1, until count==MAX_COUNT. It then holds, and o_saturated sets in the same cycle o_count shows MAX_COUNT.
- S_IDLE + i_start -> S_RUN on the next cycle, with count<=0, o_timeout<=0, o_saturated<=0. The start cycle itself never counts.
- Next-count rule: next = count + (i_en && count<MAX_COUNT).
- S_RUN + i_stop:
  - o_capture <= next, so the stop cycle's tick is included.
  - o_valid=1 for exactly the following cycle.
  - State -> S_IDLE; count holds at the captured value.
- Measurement identity: with i_en held high, start at cycle N and stop at cycle N+k give o_capture=k, valid at N+k+1.
- S_RUN + i_start, no stop: restart. count<=0, flags cleared, no capture, no o_valid.
- S_RUN + i_start + i_stop in the same cycle: capture as for stop (o_valid next cycle), then restart (count<=0, flags cleared, remain S_RUN). Back-to-back intervals lose no tick.
- o_timeout: set when next==TIMEOUT_COUNT in S_RUN, so it is high in the same cycle o_count==TIMEOUT_COUNT. It does not stop the count. Cleared only by start, clear or reset.
- i_clear:
  - Effects: S_IDLE, count 0, o_valid 0, timeout and saturated flags cleared; o_capture retained.
  - Mid-measurement it discards the measurement; a coincident i_stop is dropped.
- i_rst mid-measurement: all outputs to reset values in the next cycle.
- Arithmetic: unsigned only. No wrap-around is possible because of saturation.
- Elaboration assertions (fatal): MAX_COUNT>0; 1<=TIMEOUT_COUNT<=MAX_COUNT; 2**COUNTER_WIDTH > MAX_COUNT.

Decomposition:
- Shared package mil1553_timer_pkg:
  - typedef enum logic {S_IDLE, S_RUN} timer_state_t.
  - Tick constants for 1553 at the system clock: RESP_GAP_MIN (4 us), RESP_GAP_MAX (12 us), NO_RESP_TIMEOUT (14 us).
- One natural sub-module, sat_up_counter: clear/enable/saturating increment exposing next and count. The FSM, capture and flag logic stay in elapsed_timer.

Test Plan:
All scenarios use MAX_COUNT=20 and TIMEOUT_COUNT=14, i_en=1 unless stated.
- Basic interval: start at cycle 10, stop at cycle 17 -> o_valid high at cycle 18 only, o_capture=7, o_running low from 18, o_timeout=0.
- Gated enable: i_en high every other cycle; start at 0, stop at 10 -> o_capture=5 (5 enabled ticks in cycles 1-10).
- Timeout and saturation: start, no stop -> o_timeout rises with o_count==14; o_saturated rises with o_count==20; count holds 20 for 5 more cycles; stop -> o_capture=20, both flags still 1.
- Back-to-back: start at 0, start+stop at 6, stop at 9 -> captures 6 then 3; o_valid at 7 and 10; no gap in o_running.
- Abort paths: start, then i_clear+i_stop at cycle 5 -> no o_valid, o_capture keeps prior value, idle; i_stop in idle ignored; i_rst at cycle 3 of a run -> all outputs at reset values next cycle.
- Restart without stop: start at 0, start at 4, stop at 7 -> single o_valid, o_capture=3, timeout flag from the first run cleared.

Source files
------------

// File: rtl/mil1553_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mil1553_timer_pkg : shared state type and 1553 tick constants         |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package mil1553_timer_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } timer_state_t;

  localparam int unsigned SYS_CLK_MHZ = 100;

  function automatic int unsigned us_to_ticks(input int unsigned us);
    return us * SYS_CLK_MHZ;
  endfunction

  localparam int unsigned RESP_GAP_MIN    = us_to_ticks(4);
  localparam int unsigned RESP_GAP_MAX    = us_to_ticks(12);
  localparam int unsigned NO_RESP_TIMEOUT = us_to_ticks(14);

endpackage
`default_nettype wire

// File: rtl/sat_up_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_up_counter : clearable, enabled up-counter that stops at MAX_COUNT|
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module sat_up_counter #(
  parameter int unsigned MAX_COUNT     = 1000,
  parameter int unsigned COUNTER_WIDTH = $clog2(MAX_COUNT + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  output logic [COUNTER_WIDTH-1:0] o_count,
  output logic [COUNTER_WIDTH-1:0] o_next
);

  localparam logic [COUNTER_WIDTH-1:0] C_MAX = COUNTER_WIDTH'(MAX_COUNT);

  logic [COUNTER_WIDTH-1:0] count_q;
  logic [COUNTER_WIDTH-1:0] count_d;
  logic                     w_inc;

  // o_next is the value the count would take without a clear; the caller
  // uses it to capture the stop cycle's own tick.
  always_comb begin
    w_inc   = i_en && (count_q < C_MAX);
    o_next  = count_q + COUNTER_WIDTH'(w_inc);
    count_d = i_clr ? '0 : o_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/elapsed_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elapsed_timer : saturating start/stop interval timer with capture    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module elapsed_timer
  import mil1553_timer_pkg::*;
#(
  parameter int unsigned MAX_COUNT     = 1000,
  parameter int unsigned TIMEOUT_COUNT = 700,
  parameter int unsigned COUNTER_WIDTH = $clog2(MAX_COUNT + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic                     i_start,
  input  logic                     i_stop,
  output logic [COUNTER_WIDTH-1:0] o_count,
  output logic                     o_running,
  output logic [COUNTER_WIDTH-1:0] o_capture,
  output logic                     o_valid,
  output logic                     o_timeout,
  output logic                     o_saturated
);

  localparam logic [COUNTER_WIDTH-1:0] C_MAX     = COUNTER_WIDTH'(MAX_COUNT);
  localparam logic [COUNTER_WIDTH-1:0] C_TIMEOUT = COUNTER_WIDTH'(TIMEOUT_COUNT);

  if (MAX_COUNT == 0) begin : g_chk_max
    $fatal(1, "elapsed_timer: MAX_COUNT must be > 0");
  end
  if ((TIMEOUT_COUNT < 1) || (TIMEOUT_COUNT > MAX_COUNT)) begin : g_chk_timeout
    $fatal(1, "elapsed_timer: TIMEOUT_COUNT must lie in 1..MAX_COUNT");
  end
  if ((64'(1) << COUNTER_WIDTH) <= 64'(MAX_COUNT)) begin : g_chk_width
    $fatal(1, "elapsed_timer: COUNTER_WIDTH too narrow for MAX_COUNT");
  end

  timer_state_t             state_q, state_d;
  logic [COUNTER_WIDTH-1:0] capture_q, capture_d;
  logic                     valid_q, valid_d;
  logic                     timeout_q, timeout_d;
  logic                     saturated_q, saturated_d;

  logic                     w_running;
  logic                     w_cnt_clr;
  logic                     w_cnt_en;
  logic [COUNTER_WIDTH-1:0] w_count;
  logic [COUNTER_WIDTH-1:0] w_next;

  // Any start zeroes the count, whether from idle, a restart, or start+stop.
  assign w_running = (state_q == S_RUN);
  assign w_cnt_clr = i_clear || i_start;
  assign w_cnt_en  = w_running && i_en;

  sat_up_counter #(
    .MAX_COUNT    (MAX_COUNT),
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_counter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_count(w_count),
    .o_next (w_next)
  );

  always_comb begin
    state_d     = state_q;
    capture_d   = capture_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;
    saturated_d = saturated_q;
    if (i_clear) begin
      state_d     = S_IDLE;
      timeout_d   = 1'b0;
      saturated_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d     = S_RUN;
            timeout_d   = 1'b0;
            saturated_d = 1'b0;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            capture_d = w_next;
            valid_d   = 1'b1;
            if (!i_start) begin
              state_d = S_IDLE;
            end
          end
          // Flags track next so they rise in the cycle o_count shows the value.
          if (i_start) begin
            timeout_d   = 1'b0;
            saturated_d = 1'b0;
          end else begin
            if (w_next == C_TIMEOUT) timeout_d   = 1'b1;
            if (w_next == C_MAX)     saturated_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      capture_q   <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      capture_q   <= capture_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      saturated_q <= saturated_d;
    end
  end

  assign o_count     = w_count;
  assign o_running   = w_running;
  assign o_capture   = capture_q;
  assign o_valid     = valid_q;
  assign o_timeout   = timeout_q;
  assign o_saturated = saturated_q;

endmodule
`default_nettype wire
